// File: rtl/sorted_serializer_pkg.sv
// Shared sizing for the sorter output stage.
// Also holds a helper that gives the number of beats per sorted vector.
package sorted_serializer_pkg;

  localparam int unsigned SORT_P_LOG = 9;
  localparam int unsigned SORT_DATW  = 64;
  localparam int unsigned SORT_KEYW  = 32;
  localparam int unsigned SER_W_LOG  = 2;

  function automatic int unsigned beats_per_vec(input int unsigned p_log,
                                                input int unsigned w_log);
    return 32'(1) << (p_log - w_log);
  endfunction

endpackage

// File: rtl/key_order_chk.sv
// Flags a descending key inside one output beat, or at the seam with the previous beat.
// Purely combinational; keys are the low KEYW bits of each record and compare unsigned.
module key_order_chk
  import sorted_serializer_pkg::*;
#(
  parameter int unsigned DATW  = SORT_DATW,
  parameter int unsigned KEYW  = SORT_KEYW,
  parameter int unsigned W_LOG = SER_W_LOG
) (
  input  logic [(DATW<<W_LOG)-1:0] beat,
  input  logic [KEYW-1:0]          prior_key,
  input  logic                     first_beat,
  output logic                     desc
);

  localparam int unsigned NREC = 1 << W_LOG;

  logic [KEYW-1:0] keys [NREC];
  logic            unused_payload;

  // Payload bits above the key play no part in ordering.
  assign unused_payload = ^beat;

  always_comb begin
    desc = 1'b0;
    for (int r = 0; r < NREC; r++) begin
      keys[r] = beat[r*DATW +: KEYW];
    end
    for (int r = 1; r < NREC; r++) begin
      if (keys[r] < keys[r-1]) desc = 1'b1;
    end
    if (!first_beat && (keys[0] < prior_key)) desc = 1'b1;
  end

endmodule

// File: rtl/sorted_serializer.sv
// Two-slot buffer behind the sorting network: captures whole sorted vectors and
// replays them as narrow beats under valid/ready, flagging drops and order errors.
module sorted_serializer
  import sorted_serializer_pkg::*;
#(
  parameter int unsigned P_LOG = SORT_P_LOG,
  parameter int unsigned DATW  = SORT_DATW,
  parameter int unsigned KEYW  = SORT_KEYW,
  parameter int unsigned W_LOG = SER_W_LOG
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [(DATW<<P_LOG)-1:0] DIN,
  input  logic                     DINEN,
  output logic [(DATW<<W_LOG)-1:0] DOT,
  output logic                     DOTEN,
  input  logic                     DOTRDY,
  output logic                     DOTLAST,
  output logic                     OVFL,
  output logic                     ORDERR
);

  localparam int unsigned VECW  = DATW << P_LOG;
  localparam int unsigned BEATW = DATW << W_LOG;
  localparam int unsigned NBEAT = beats_per_vec(P_LOG, W_LOG);
  localparam int unsigned IDXW  = (P_LOG > W_LOG) ? (P_LOG - W_LOG) : 1;

  logic [VECW-1:0] slot [2];

  logic [1:0]      valid, valid_nxt;
  logic            hp, hp_nxt;
  logic            tp, tp_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [KEYW-1:0] lastkey, lastkey_nxt;
  logic            ovfl_nxt, orderr_nxt;

  logic            last_idx, xfer, final_xfer, wr, desc;
  logic [BEATW-1:0] beat;

  // Beat mux straight from the head slot; only the head slot feeds DOT.
  assign beat = slot[hp][32'(idx) * BEATW +: BEATW];
  assign DOT  = beat;

  key_order_chk #(
    .DATW  (DATW),
    .KEYW  (KEYW),
    .W_LOG (W_LOG)
  ) u_key_order_chk (
    .beat       (beat),
    .prior_key  (lastkey),
    .first_beat (idx == '0),
    .desc       (desc)
  );

  always_comb begin
    valid_nxt   = valid;
    hp_nxt      = hp;
    tp_nxt      = tp;
    idx_nxt     = idx;
    lastkey_nxt = lastkey;
    ovfl_nxt    = OVFL;
    orderr_nxt  = ORDERR;

    last_idx   = (idx == IDXW'(NBEAT - 1));
    DOTEN      = valid[hp];
    DOTLAST    = valid[hp] && last_idx;
    xfer       = DOTEN && DOTRDY;
    final_xfer = xfer && last_idx;
    // A full buffer still accepts a vector when the head slot empties this cycle.
    wr         = DINEN && (!valid[tp] || (final_xfer && (hp == tp)));

    if (xfer) begin
      idx_nxt     = last_idx ? '0 : idx + 1'b1;
      lastkey_nxt = beat[BEATW-DATW +: KEYW];
      if (desc) orderr_nxt = 1'b1;
      if (last_idx) begin
        valid_nxt[hp] = 1'b0;
        hp_nxt        = ~hp;
      end
    end

    // Set after clear so a write into the slot being freed keeps it valid.
    if (wr) begin
      valid_nxt[tp] = 1'b1;
      tp_nxt        = ~tp;
    end else if (DINEN) begin
      ovfl_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid   <= 2'b00;
      hp      <= 1'b0;
      tp      <= 1'b0;
      idx     <= '0;
      lastkey <= '0;
      OVFL    <= 1'b0;
      ORDERR  <= 1'b0;
    end else begin
      valid   <= valid_nxt;
      hp      <= hp_nxt;
      tp      <= tp_nxt;
      idx     <= idx_nxt;
      lastkey <= lastkey_nxt;
      OVFL    <= ovfl_nxt;
      ORDERR  <= orderr_nxt;
    end
  end

  // Vector storage carries no reset; contents are qualified by valid.
  always_ff @(posedge CLK) begin
    if (wr) slot[tp] <= DIN;
  end

endmodule

// File: tb/tb_sorted_serializer.sv
// Scoreboard bench for sorted_serializer: stimulus queues expected beats,
// an independent monitor compares every presented beat against the queue head.
module tb_sorted_serializer;

  localparam int unsigned P_LOG = 9;
  localparam int unsigned DATW  = 64;
  localparam int unsigned KEYW  = 32;
  localparam int unsigned W_LOG = 2;
  localparam int unsigned NREC  = 1 << P_LOG;
  localparam int unsigned RPB   = 1 << W_LOG;
  localparam int unsigned NBEAT = NREC / RPB;
  localparam int unsigned VECW  = DATW * NREC;
  localparam int unsigned BEATW = DATW * RPB;

  typedef struct {
    logic [BEATW-1:0] dot;
    logic             last;
  } exp_t;

  exp_t exp_q[$];

  logic             CLK;
  logic             RST;
  logic [VECW-1:0]  DIN;
  logic             DINEN;
  logic [BEATW-1:0] DOT;
  logic             DOTEN;
  logic             DOTRDY;
  logic             DOTLAST;
  logic             OVFL;
  logic             ORDERR;

  int n_cmp;
  int n_err;
  int xfer_cnt;
  int gap_cnt;

  sorted_serializer #(
    .P_LOG (P_LOG),
    .DATW  (DATW),
    .KEYW  (KEYW),
    .W_LOG (W_LOG)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .DINEN   (DINEN),
    .DOT     (DOT),
    .DOTEN   (DOTEN),
    .DOTRDY  (DOTRDY),
    .DOTLAST (DOTLAST),
    .OVFL    (OVFL),
    .ORDERR  (ORDERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Sorted output of the network for input keys 512..1: record i has key i+1.
  // Records sa and sb are exchanged to model a faulty sorter; payload tags the source record.
  function automatic int src_of(input int rec, input int sa, input int sb);
    if (rec == sa) return sb;
    if (rec == sb) return sa;
    return rec;
  endfunction

  function automatic logic [DATW-1:0] rec_val(input int tag, input int rec, input int sa, input int sb);
    int s;
    s = src_of(rec, sa, sb);
    return {16'(tag), 16'(s), 32'(s + 1)};
  endfunction

  function automatic logic [VECW-1:0] make_vec(input int tag, input int sa, input int sb);
    logic [VECW-1:0] v;
    v = '0;
    for (int i = 0; i < NREC; i++) v[i*DATW +: DATW] = rec_val(tag, i, sa, sb);
    return v;
  endfunction

  function automatic logic [BEATW-1:0] exp_beat(input int tag, input int j, input int sa, input int sb);
    logic [BEATW-1:0] b;
    b = '0;
    for (int r = 0; r < RPB; r++) b[r*DATW +: DATW] = rec_val(tag, j*RPB + r, sa, sb);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input int tag, input int sa, input int sb);
    exp_t e;
    for (int j = 0; j < NBEAT; j++) begin
      e.dot  = exp_beat(tag, j, sa, sb);
      e.last = (j == NBEAT - 1);
      exp_q.push_back(e);
    end
  endtask

  // One-cycle DINEN pulse; returns 1 time unit after the capturing edge.
  task automatic pulse(input int tag, input int sa, input int sb, input bit accept);
    DIN   = make_vec(tag, sa, sb);
    DINEN = 1'b1;
    @(posedge CLK);
    if (accept) push_vec(tag, sa, sb);
    #1;
    DINEN = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge CLK);
      c++;
    end
    #1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: every presented beat must match the queue head; pop on transfer.
  always @(negedge CLK) begin
    if (!RST && DOTEN) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_beat: got DOTEN=1 DOT=%h expected no beat", DOT);
      end else begin
        n_cmp++;
        if (DOT !== exp_q[0].dot || DOTLAST !== exp_q[0].last) begin
          n_err++;
          $display("FAIL beat: got DOT=%h LAST=%b expected DOT=%h LAST=%b",
                   DOT, DOTLAST, exp_q[0].dot, exp_q[0].last);
        end
        if (DOTRDY) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
    end else if (!RST && !DOTEN && exp_q.size() > 0) begin
      gap_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int c;
    n_cmp = 0; n_err = 0; xfer_cnt = 0; gap_cnt = 0;
    RST = 1'b1; DINEN = 1'b0; DOTRDY = 1'b0; DIN = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rst_doten",   64'(DOTEN),   64'd0);
    check("rst_dotlast", 64'(DOTLAST), 64'd0);
    check("rst_ovfl",    64'(OVFL),    64'd0);
    check("rst_orderr",  64'(ORDERR),  64'd0);

    // Single vector, full throughput, one-cycle latency.
    DOTRDY = 1'b1;
    base = xfer_cnt;
    pulse(1, -1, -1, 1'b1);
    check("s1_latency_doten", 64'(DOTEN), 64'd1);
    wait_drain(400);
    check("s1_xfers",  64'(xfer_cnt - base), 64'd128);
    check("s1_idle",   64'(DOTEN),  64'd0);
    check("s1_ovfl",   64'(OVFL),   64'd0);
    check("s1_orderr", 64'(ORDERR), 64'd0);

    // Back-to-back vectors stream with no gap; first beat not compared to old key.
    gap_cnt = 0;
    base = xfer_cnt;
    pulse(2, -1, -1, 1'b1);
    pulse(3, -1, -1, 1'b1);
    wait_drain(600);
    check("s2_gap",    64'(gap_cnt), 64'd0);
    check("s2_xfers",  64'(xfer_cnt - base), 64'd256);
    check("s2_ovfl",   64'(OVFL),   64'd0);
    check("s2_orderr", 64'(ORDERR), 64'd0);

    // Third pulse in three cycles is dropped.
    pulse(4, -1, -1, 1'b1);
    pulse(5, -1, -1, 1'b1);
    check("s3_ovfl_pre", 64'(OVFL), 64'd0);
    pulse(6, -1, -1, 1'b0);
    check("s3_ovfl_drop", 64'(OVFL), 64'd1);
    wait_drain(600);
    check("s3_ovfl_sticky", 64'(OVFL), 64'd1);
    do_reset();
    check("s3_ovfl_cleared", 64'(OVFL), 64'd0);

    // Write coinciding with the head vector's final beat lands in the freed slot.
    pulse(7, -1, -1, 1'b1);
    pulse(8, -1, -1, 1'b1);
    repeat (126) @(posedge CLK);
    #1;
    check("s3b_head_on_last", 64'(DOTLAST), 64'd1);
    pulse(9, -1, -1, 1'b1);
    check("s3b_ovfl", 64'(OVFL), 64'd0);
    wait_drain(900);
    check("s3b_ovfl_end", 64'(OVFL), 64'd0);

    // Stalls: 1-on/2-off ready, DOT held while stalled.
    DOTRDY = 1'b0;
    base = xfer_cnt;
    pulse(10, -1, -1, 1'b1);
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      DOTRDY = (c % 3 == 0);
      @(posedge CLK);
      #1;
      c++;
    end
    check("s4_drain", 64'(exp_q.size()), 64'd0);
    check("s4_xfers", 64'(xfer_cnt - base), 64'd128);
    exp_q.delete();

    // Seam error: records 3/4 swapped, flagged on beat 1 only.
    DOTRDY = 1'b0;
    pulse(11, 3, 4, 1'b1);
    DOTRDY = 1'b1;
    @(posedge CLK);
    #1;
    check("s5_orderr_beat0", 64'(ORDERR), 64'd0);
    @(posedge CLK);
    #1;
    check("s5_orderr_beat1", 64'(ORDERR), 64'd1);
    wait_drain(400);
    check("s5_orderr_sticky", 64'(ORDERR), 64'd1);
    do_reset();
    check("s5_orderr_cleared", 64'(ORDERR), 64'd0);

    // In-beat error: records 0/1 swapped, flagged on the first transfer.
    DOTRDY = 1'b0;
    pulse(12, 0, 1, 1'b1);
    check("s5b_orderr_pre", 64'(ORDERR), 64'd0);
    DOTRDY = 1'b1;
    @(posedge CLK);
    #1;
    check("s5b_orderr_beat0", 64'(ORDERR), 64'd1);
    wait_drain(400);

    // Reset mid-vector at beat 60, then a clean vector from beat 0.
    base = xfer_cnt;
    pulse(13, -1, -1, 1'b1);
    c = 0;
    while ((xfer_cnt - base) < 60 && c < 500) begin
      @(posedge CLK);
      c++;
    end
    #1;
    check("s6_at_beat60", 64'(xfer_cnt - base), 64'd60);
    RST = 1'b1;
    exp_q.delete();
    #1;
    check("s6_rst_doten",   64'(DOTEN),   64'd0);
    check("s6_rst_dotlast", 64'(DOTLAST), 64'd0);
    check("s6_rst_orderr",  64'(ORDERR),  64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    base = xfer_cnt;
    pulse(14, -1, -1, 1'b1);
    check("s6_restart_doten", 64'(DOTEN), 64'd1);
    wait_drain(400);
    check("s6_xfers",  64'(xfer_cnt - base), 64'd128);
    check("s6_ovfl",   64'(OVFL),   64'd0);
    check("s6_orderr", 64'(ORDERR), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sorted_serializer.md
# sorted_serializer

Downstream stage of the even-odd merge sorting network. It captures each sorted vector of 2^P_LOG records that the sorter emits as a single-cycle DOTEN pulse, and holds up to two vectors. It replays each vector as a stream of 2^W_LOG-record beats, in ascending key order, under a valid/ready handshake. The sorter has no back-pressure, so this block absorbs bursts, flags dropped vectors, and checks the sort order of every record it emits.

## Interface
- P_LOG, 9, log2 records per sorted vector (same value as the sorter)
- DATW, 64, record width in bits
- KEYW, 32, key width; the key is the low KEYW bits of each record
- W_LOG, 2, log2 records per output beat; 0 ≤ W_LOG ≤ P_LOG
- CLK  in  1  clock; all state is updated on the rising edge
- RST  in  1  reset, asynchronous, active-high
- DIN  in  DATW<<P_LOG  sorted vector from the sorter's DOT; record i occupies bits [DATW*(i+1)-1:DATW*i]
- DINEN  in  1  vector valid, from the sorter's DOTEN; single-cycle, cannot be stalled
- DOT  out  DATW<<W_LOG  current output beat; record j of the beat is in slice j
- DOTEN  out  1  beat valid
- DOTRDY  in  1  downstream ready
- DOTLAST  out  1  current beat is the last beat of its vector
- OVFL  out  1  sticky: at least one vector was dropped
- ORDERR  out  1  sticky: a key was emitted that is smaller than its predecessor in the same vector

## Operation
- Storage is two slots of DATW<<P_LOG bits each.
  - Per-slot valid bits.
  - Head pointer hp (1 bit) and tail pointer tp (1 bit).
  - Beat index idx, P_LOG-W_LOG bits wide; idx is absent when W_LOG==P_LOG.
- A transfer occurs when DOTEN && DOTRDY.
- Write path:
  - On DINEN with slot[tp] free, or with slot[tp] being freed this cycle: store DIN into slot[tp], set its valid bit, toggle tp.
  - On DINEN with both slots valid and no final-beat transfer this cycle: drop the vector and set OVFL. Slots and pointers are unchanged.
- Read path:
  - DOTEN = valid[hp].
  - DOT = records idx·2^W_LOG … idx·2^W_LOG+2^W_LOG-1 of slot[hp]. This is a combinational mux from registers.
  - DOTLAST = DOTEN && idx == all-ones. When W_LOG==P_LOG, DOTLAST = DOTEN.
  - On a transfer: idx increments. On the last beat, idx wraps to 0, valid[hp] clears and hp toggles.
- Simultaneous write and final-beat transfer with both slots full: the write lands in the slot being freed, and OVFL is not set.
- Order check:
  - Register lastkey holds the key of the final record of the previous beat.
  - On each transfer, set ORDERR if any adjacent pair within the beat is descending.
  - Also set ORDERR if idx≠0 and the beat's first key < lastkey.
  - Keys compare as unsigned. Equal keys are legal.
  - The first beat of each vector is not compared against lastkey.
- DOT and DOTLAST hold steady while DOTEN && !DOTRDY. A late vector arriving on DINEN never alters the beat currently presented.

## Timing
- Reset values: DOTEN=0, DOTLAST=0, OVFL=0, ORDERR=0, hp=tp=0, idx=0, valid=00, lastkey=0. DOT content is don't-care, but is X-free after the first write.
- Latency: DINEN at edge n gives DOTEN=1 after edge n, i.e. one cycle later, provided the block was empty.
- Throughput: one beat per cycle while DOTRDY=1. A vector takes 2^(P_LOG-W_LOG) cycles (128 with the defaults).
- Back-to-back DINEN pulses are accepted into both slots. A third pulse arriving before the head vector finishes is dropped.
- RST mid-stream: state clears immediately and asynchronously. Any partially emitted vector is discarded with no DOTLAST. OVFL and ORDERR clear.

## Structure
- P_LOG, DATW and KEYW come from the shared header used by the sorter and the benches. W_LOG is local to this block.
- One sub-module, key_order_chk. It is combinational: it takes a beat plus the prior key and a first-beat flag, and returns a descending flag. Instantiate it once.
- Slot storage, pointers, the idx counter and the sticky flags live in the top module.

## Test plan
Use the default parameters. Each scenario drives its DIN through a real EVEN_ODD instance or a model of it.
- Reset, then one vector with keys 512…1, DOTRDY=1 → 128 beats; beat 0 keys 1,2,3,4; DOTLAST only on beat 127 (keys 509–512); ORDERR=0, OVFL=0.
- Two DINEN pulses on consecutive cycles, DOTRDY=1 → 256 beats with no gap and DOTLAST twice; OVFL=0.
- Three DINEN pulses in 3 cycles → the first two vectors are emitted in full and the third is dropped; OVFL=1 from the third pulse's edge onward.
- DOTRDY toggled in a 1-on/2-off pattern → DOT stable across stalls, beat sequence identical to the first scenario, 128 transfers.
- DIN with keys 1..512 except records 4 and 3 swapped (crossing beats 0/1), plus a second vector with records 0 and 1 swapped → ORDERR=1 after the transfer of the offending beat; the emitted data is unmodified.
- Assert RST at beat 60 of a vector → DOTEN=0 immediately. After release, a new vector is emitted from beat 0 with OVFL=0 and ORDERR=0.
